// File: rtl/rams_arb_pkg.sv
// Shared sizes and state/owner encodings for the two-port RAM arbiter.
package rams_arb_pkg;
    localparam int DEPTH_DEF = 1024;
    localparam int AW_DEF    = 10;
    localparam int DW_DEF    = 16;

    typedef enum logic {CLEAR, SERVE} state_t;
    typedef enum logic [1:0] {NONE, A, B} owner_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers which side won last.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid_a,
    input  logic valid_b,
    input  logic enable,
    output logic grant_a,
    output logic grant_b
);
    logic last_b;

    // On contention the side that did not win last time gets the port.
    always_comb begin
        grant_a = enable & valid_a & (~valid_b | last_b);
        grant_b = enable & valid_b & (~valid_a | ~last_b);
    end

    // Pointer moves only when somebody is actually granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_b <= 1'b0;
        else if (grant_a | grant_b)
            last_b <= grant_b;
    end
endmodule

// File: rtl/rams_sp_arb2_1024x16.sv
// Clear sequencer plus A/B round-robin front end for a write-first 1024x16 RAM.
module rams_sp_arb2_1024x16
    import rams_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_we,
    output logic          ram_rst,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_dout
);
    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] di_q;
    logic [DW-1:0] a_hold, b_hold;
    owner_t        last_owner, owner_nx;
    logic          grant_a, grant_b;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_a (a_valid),
        .valid_b (b_valid),
        .enable  (state == SERVE),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign busy    = (state == CLEAR);

    // State register and clear counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Sweep every address once, then serve until a clear is requested.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CLEAR: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nx = SERVE;
                    cnt_nx   = '0;
                end
            end
            SERVE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    // RAM port mux; address/data park on their last driven value when idle.
    // ram_we is gated by rst so it drops immediately while reset is held.
    always_comb begin
        ram_we   = 1'b0;
        ram_rst  = (state == CLEAR);
        ram_addr = addr_q;
        ram_di   = di_q;
        owner_nx = NONE;
        if (state == CLEAR) begin
            ram_we   = rst;
            ram_addr = cnt;
            ram_di   = '0;
        end else if (grant_a) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_di   = a_wdata;
            owner_nx = A;
        end else if (grant_b) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_di   = b_wdata;
            owner_nx = B;
        end
    end

    // Response routing: RAM output goes to whoever was granted last cycle.
    assign a_rvalid = (last_owner == A);
    assign b_rvalid = (last_owner == B);
    assign a_rdata  = a_rvalid ? ram_dout : a_hold;
    assign b_rdata  = b_rvalid ? ram_dout : b_hold;

    // Remember last driven RAM inputs, the pending owner and held read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            di_q       <= '0;
            last_owner <= NONE;
            a_hold     <= '0;
            b_hold     <= '0;
        end else begin
            addr_q     <= ram_addr;
            di_q       <= ram_di;
            last_owner <= owner_nx;
            a_hold     <= a_rdata;
            b_hold     <= b_rdata;
        end
    end
endmodule

// File: tb/tb_rams_sp_arb2_1024x16.sv
// Scoreboard bench: RAM model + reference arbiter/memory, responses queued at grant.
module tb_rams_sp_arb2_1024x16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_req;
    logic          busy;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          ram_we, ram_rst;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_dout;

    rams_sp_arb2_1024x16 dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_we   (ram_we),
        .ram_rst  (ram_rst),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Write-first single-port RAM with synchronous output reset.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_di;
        if (ram_rst)     ram_dout <= '0;
        else if (ram_we) ram_dout <= ram_di;
        else             ram_dout <= mem[ram_addr];
    end

    typedef struct {
        bit            side_b;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            clr_left;
    bit            m_last_b;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_di, a_hold, b_hold;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_mem();
        foreach (ref_mem[i]) ref_mem[i] = '0;
    endtask

    // One clock: check outputs at negedge against the model, then advance.
    task automatic step();
        rsp_t          e;
        bit            ga, gb, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("a_rvalid", 32'(a_rvalid), 32'(!e.side_b));
            chk("b_rvalid", 32'(b_rvalid), 32'(e.side_b));
            if (e.side_b) b_hold = e.data;
            else          a_hold = e.data;
        end else begin
            chk("a_rvalid_idle", 32'(a_rvalid), 32'(0));
            chk("b_rvalid_idle", 32'(b_rvalid), 32'(0));
        end
        chk("a_rdata", 32'(a_rdata), 32'(a_hold));
        chk("b_rdata", 32'(b_rdata), 32'(b_hold));
        chk("busy", 32'(busy), 32'(clr_left != 0));
        if (clr_left != 0) begin
            chk("clr_a_ready", 32'(a_ready), 32'(0));
            chk("clr_b_ready", 32'(b_ready), 32'(0));
            chk("clr_ram_we", 32'(ram_we), 32'(1));
            chk("clr_ram_rst", 32'(ram_rst), 32'(1));
            chk("clr_ram_addr", 32'(ram_addr), 32'(DEPTH - clr_left));
            chk("clr_ram_di", 32'(ram_di), 32'(0));
            h_addr = AW'(DEPTH - clr_left);
            h_di   = '0;
            clr_left--;
        end else begin
            ga = a_valid && (!b_valid || m_last_b);
            gb = b_valid && (!a_valid || !m_last_b);
            chk("a_ready", 32'(a_ready), 32'(ga));
            chk("b_ready", 32'(b_ready), 32'(gb));
            chk("srv_ram_rst", 32'(ram_rst), 32'(0));
            if (ga || gb) begin
                we = ga ? a_we    : b_we;
                ad = ga ? a_addr  : b_addr;
                wd = ga ? a_wdata : b_wdata;
                chk("ram_we", 32'(ram_we), 32'(we));
                chk("ram_addr", 32'(ram_addr), 32'(ad));
                chk("ram_di", 32'(ram_di), 32'(wd));
                h_addr = ad;
                h_di   = wd;
                if (we) ref_mem[ad] = wd;
                exp_q.push_back('{side_b: gb, data: ref_mem[ad]});
                m_last_b = gb;
            end else begin
                chk("idle_ram_we", 32'(ram_we), 32'(0));
                chk("idle_ram_addr", 32'(ram_addr), 32'(h_addr));
                chk("idle_ram_di", 32'(ram_di), 32'(h_di));
            end
            if (clr_req) begin
                clr_left = DEPTH;
                model_clear_mem();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset, check asynchronous reset values, release after one edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_a_ready", 32'(a_ready), 32'(0));
        chk("rst_b_ready", 32'(b_ready), 32'(0));
        chk("rst_a_rvalid", 32'(a_rvalid), 32'(0));
        chk("rst_b_rvalid", 32'(b_rvalid), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_ram_rst", 32'(ram_rst), 32'(1));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_ram_di", 32'(ram_di), 32'(0));
        chk("rst_a_rdata", 32'(a_rdata), 32'(0));
        chk("rst_b_rdata", 32'(b_rdata), 32'(0));
        exp_q.delete();
        clr_left = DEPTH;
        m_last_b = 1'b0;
        h_addr   = '0;
        h_di     = '0;
        a_hold   = '0;
        b_hold   = '0;
        model_clear_mem();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drive_a(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_valid = v; a_we = w; a_addr = ad; a_wdata = d;
    endtask

    task automatic drive_b(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_valid = v; b_we = w; b_addr = ad; b_wdata = d;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst     = 1'b0;
        clr_req = 1'b0;
        drive_a(1'b1, 1'b0, '0, '0);
        drive_b(1'b1, 1'b0, '0, '0);
        #2;

        // Reset/clear with both requesters pending throughout
        do_reset();
        run(DEPTH);
        idle();
        drive_a(1'b1, 1'b0, 10'h3FF, '0); step();
        idle(); step();
        chk("clr_read_3ff", 32'(a_hold), 32'(0));

        // Single requester A: write then read back
        drive_a(1'b1, 1'b1, 10'h010, 16'h1234); step();
        drive_a(1'b1, 1'b0, 10'h010, 16'h0000); step();
        idle(); step();
        chk("a_readback", 32'(a_rdata), 32'h1234);

        // B access so A holds priority for the contention burst
        drive_b(1'b1, 1'b0, 10'h010, '0); step();
        idle(); step();
        chk("b_readback", 32'(b_rdata), 32'h1234);

        // Contention: A reads 0x020, B writes 0xBEEF there; grants A,B,A,B
        drive_a(1'b1, 1'b0, 10'h020, '0);
        drive_b(1'b1, 1'b1, 10'h020, 16'hBEEF);
        run(4);
        idle(); step();
        chk("contend_a_sees_b", 32'(a_rdata), 32'hBEEF);

        // Clear request after dirtying the top word
        drive_a(1'b1, 1'b1, 10'h3FF, 16'hFFFF); step();
        idle(); clr_req = 1'b1; step();
        clr_req = 1'b0;
        run(DEPTH);
        drive_a(1'b1, 1'b0, 10'h3FF, '0); step();
        idle(); step();
        chk("clrreq_read_3ff", 32'(a_rdata), 32'(0));

        // Mid-clear reset at count 500, then a full restarted sweep
        clr_req = 1'b1; step();
        clr_req = 1'b0;
        run(500);
        chk("midclr_addr", 32'(ram_addr), 32'(500));
        do_reset();
        run(DEPTH);

        // Random co-simulation
        for (int i = 0; i < 3000; i++) begin
            drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 15)),
                    DW'($urandom));
            drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), DW'($urandom));
            clr_req = ($urandom_range(0, 499) == 0);
            step();
        end
        clr_req = 1'b0;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
